// File: rtl/panel_stream_pkg.sv
// Shared definitions for the panel pixel-write stream parser and the LED panel drivers.
// Optional statistics counters are enabled with `STREAM_STATS_EN (see panel_stream_writer).
package panel_stream_pkg;

  // Parser states, kept as plain constants for compatibility with older tools.
  typedef logic [2:0] stream_state_t;
  localparam stream_state_t ST_IDLE    = 3'd0;
  localparam stream_state_t ST_HDR_ROW = 3'd1;
  localparam stream_state_t ST_HDR_COL = 3'd2;
  localparam stream_state_t ST_PIX_HI  = 3'd3;
  localparam stream_state_t ST_PIX_LO  = 3'd4;
  localparam stream_state_t ST_DROP    = 3'd5;

  localparam logic [7:0] EN_IDLE = 8'hFF;

  localparam int HDR_PANEL = 0;
  localparam int HDR_ROW   = 1;
  localparam int HDR_COL   = 2;

  // RGB565 layout on ctrl_wdat: {B, G, R}.
  localparam int RGB_R_LSB = 0;
  localparam int RGB_R_MSB = 4;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_B_LSB = 11;
  localparam int RGB_B_MSB = 15;

  function automatic logic [15:0] rgb565_pack(input logic [4:0] b,
                                              input logic [5:0] g,
                                              input logic [4:0] r);
    return {b, g, r};
  endfunction

endpackage

// File: rtl/panel_stream_stats.sv
// Good-packet and error-termination counters for the panel stream parser.
// Only instantiated when `STREAM_STATS_EN is defined.
module panel_stream_stats
  import panel_stream_pkg::*;
(
  input  logic        display_clock,
  input  logic        reset,
  input  logic        pkt_ok,
  input  logic        pkt_err,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
);

  // Both counters wrap naturally modulo 2^16.
  always_ff @(posedge display_clock) begin
    if (reset) begin
      pkt_count <= '0;
      err_count <= '0;
    end else begin
      if (pkt_ok)  pkt_count <= pkt_count + 16'd1;
      if (pkt_err) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: rtl/panel_stream_writer.sv
// Parses pixel packets from the receive byte stream and drives the shared panel write bus.
// Define `STREAM_STATS_EN to add pkt_count/err_count outputs.
module panel_stream_writer
  import panel_stream_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 64,
  parameter int NUM_PANELS = 8
) (
  input  logic        display_clock,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  ctrl_en,
  output logic [15:0] ctrl_addr,
  output logic [15:0] ctrl_wdat
`ifdef STREAM_STATS_EN
  ,
  output logic [15:0] pkt_count,
  output logic [15:0] err_count
`endif
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);

  stream_state_t   state;
  logic [7:0]      panel;
  logic [YW-1:0]   row;
  logic [XW-1:0]   col;
  logic [7:0]      hi_byte;
  logic            accept;

  assign accept = s_valid && s_ready;

  // Reset has priority, so a write landing in a reset cycle never reaches the bus.
  always_ff @(posedge display_clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      panel     <= '0;
      row       <= '0;
      col       <= '0;
      hi_byte   <= '0;
      s_ready   <= 1'b0;
      ctrl_en   <= EN_IDLE;
      ctrl_addr <= '0;
      ctrl_wdat <= '0;
    end else begin
      s_ready <= 1'b1;
      ctrl_en <= EN_IDLE;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            panel <= s_data;
            if (s_last)                          state <= ST_IDLE;
            else if (int'(s_data) >= NUM_PANELS) state <= ST_DROP;
            else                                 state <= ST_HDR_ROW;
          end
          ST_HDR_ROW: begin
            row <= s_data[YW-1:0];
            if (s_last)                      state <= ST_IDLE;
            else if (int'(s_data) >= HEIGHT) state <= ST_DROP;
            else                             state <= ST_HDR_COL;
          end
          ST_HDR_COL: begin
            col <= s_data[XW-1:0];
            if (s_last)                     state <= ST_IDLE;
            else if (int'(s_data) >= WIDTH) state <= ST_DROP;
            else                            state <= ST_PIX_HI;
          end
          ST_PIX_HI: begin
            hi_byte <= s_data;
            state   <= s_last ? ST_IDLE : ST_PIX_LO;
          end
          ST_PIX_LO: begin
            ctrl_en   <= panel;
            ctrl_addr <= 16'({row, col});
            ctrl_wdat <= {hi_byte, s_data};
            // Raster-order advance: column first, row on column wrap.
            if (col == XW'(WIDTH - 1)) begin
              col <= '0;
              row <= (row == YW'(HEIGHT - 1)) ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            state <= s_last ? ST_IDLE : ST_PIX_HI;
          end
          ST_DROP: begin
            if (s_last) state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef STREAM_STATS_EN
  logic pkt_ok;
  logic pkt_err;

  // Only a packet ending on a complete pixel counts as good.
  assign pkt_ok  = accept && s_last && (state == ST_PIX_LO);
  assign pkt_err = accept && s_last && (state != ST_PIX_LO);

  panel_stream_stats u_stats (
    .display_clock (display_clock),
    .reset         (reset),
    .pkt_ok        (pkt_ok),
    .pkt_err       (pkt_err),
    .pkt_count     (pkt_count),
    .err_count     (err_count)
  );
`endif

endmodule
